// File: rtl/gpu_pkg.sv
// Shared types and screen geometry for the pixel writer slice.
// Constants match the gpu_definitions.vh screen/width macros.
package gpu_pkg;

  localparam int GPU_SCREEN_W     = 640;
  localparam int GPU_SCREEN_H     = 480;
  localparam int GPU_X_BITS       = 10;
  localparam int GPU_Y_BITS       = 9;
  localparam int GPU_CHANNEL_BITS = 8;
  localparam int GPU_ADDR_BITS    = 19;
  localparam int GPU_FIFO_DEPTH   = 4;

  typedef struct packed {
    logic [GPU_X_BITS-1:0]       x;
    logic [GPU_Y_BITS-1:0]       y;
    logic [GPU_CHANNEL_BITS-1:0] r;
    logic [GPU_CHANNEL_BITS-1:0] g;
    logic [GPU_CHANNEL_BITS-1:0] b;
  } pixel_t;

  typedef struct packed {
    logic [GPU_ADDR_BITS-1:0]      addr;
    logic [3*GPU_CHANNEL_BITS-1:0] data;
  } fb_word_t;

  typedef enum logic {
    IDLE,
    WRITE
  } wr_state_t;

endpackage

// File: rtl/gpu_pixel_fifo.sv
// Small synchronous FIFO of frame-buffer words.
// Push and pop in the same cycle leave the count unchanged.
module gpu_pixel_fifo
  import gpu_pkg::*;
#(
  parameter int FIFO_DEPTH = GPU_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  fb_word_t                    din,
  input  logic                        pop,
  output fb_word_t                    dout,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  fb_word_t      mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Storage and pointer/count bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop) count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/gpu_pixel_writer.sv
// Pixel writer: clip, address, queue and write rasterizer pixels.
// Optional macro GPU_PIXEL_DEDUP_EN drops repeats of the last (x,y).
module gpu_pixel_writer
  import gpu_pkg::*;
#(
  parameter int SCREEN_W     = GPU_SCREEN_W,
  parameter int SCREEN_H     = GPU_SCREEN_H,
  parameter int X_BITS       = GPU_X_BITS,
  parameter int Y_BITS       = GPU_Y_BITS,
  parameter int CHANNEL_BITS = GPU_CHANNEL_BITS,
  parameter int ADDR_BITS    = GPU_ADDR_BITS,
  parameter int FIFO_DEPTH   = GPU_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  input  logic [X_BITS-1:0]         pix_x,
  input  logic [Y_BITS-1:0]         pix_y,
  input  logic [CHANNEL_BITS-1:0]   pix_r,
  input  logic [CHANNEL_BITS-1:0]   pix_g,
  input  logic [CHANNEL_BITS-1:0]   pix_b,
  output logic                      mem_req,
  input  logic                      mem_ack,
  output logic [ADDR_BITS-1:0]      mem_addr,
  output logic [3*CHANNEL_BITS-1:0] mem_data,
  output logic                      busy,
  output logic                      drain_done,
  output logic [15:0]               clip_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = CW + 1;

  pixel_t          pix;
  logic            accept;
  logic            clip;
  logic            dup;
  logic            keep;
  logic            s1_valid;
  fb_word_t        s1_word;
  fb_word_t        fifo_dout;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_pop;
  logic [CW-1:0]   fifo_count;
  logic [OW-1:0]   occ;
  wr_state_t       state;
  wr_state_t       state_n;
  logic            busy_q;
  logic [ADDR_BITS-1:0] addr;

  assign pix = '{x: pix_x, y: pix_y, r: pix_r, g: pix_g, b: pix_b};

  // Ready depends only on registered occupancy, never on mem_ack.
  assign occ       = OW'(fifo_count) + OW'(s1_valid);
  assign pix_ready = !rst && (occ < OW'(FIFO_DEPTH));
  assign accept    = pix_valid && pix_ready;

  assign clip = (pix.x >= X_BITS'(SCREEN_W)) ||
                (pix.y >= Y_BITS'(SCREEN_H));
  assign addr = ADDR_BITS'(pix.y) * ADDR_BITS'(SCREEN_W) +
                ADDR_BITS'(pix.x);

`ifdef GPU_PIXEL_DEDUP_EN
  logic              last_valid;
  logic [X_BITS-1:0] last_x;
  logic [Y_BITS-1:0] last_y;

  assign dup = last_valid && (pix.x == last_x) && (pix.y == last_y);

  // Remember the last in-range point; forget it once the queue drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_valid <= 1'b0;
      last_x     <= '0;
      last_y     <= '0;
    end else if (accept && !clip) begin
      last_valid <= 1'b1;
      last_x     <= pix.x;
      last_y     <= pix.y;
    end else if (drain_done) begin
      last_valid <= 1'b0;
    end
  end
`else
  assign dup = 1'b0;
`endif

  assign keep = accept && !clip && !dup;

  // Stage 1: capture address and packed colour of kept pixels.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_word  <= '0;
    end else begin
      s1_valid <= keep;
      if (keep) s1_word <= '{addr: addr, data: {pix.r, pix.g, pix.b}};
    end
  end

  // Saturating count of off-screen pixels.
  always_ff @(posedge clk) begin
    if (rst) clip_count <= '0;
    else if (accept && clip && clip_count != 16'hFFFF)
      clip_count <= clip_count + 16'd1;
  end

  gpu_pixel_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (s1_valid && !fifo_full),
    .din  (s1_word),
    .pop  (fifo_pop),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  // Write FSM next state and FIFO pop decision.
  always_comb begin
    state_n  = state;
    fifo_pop = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_n  = WRITE;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          if (!fifo_empty) fifo_pop = 1'b1;
          else state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM state plus the held write address/data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mem_addr <= '0;
      mem_data <= '0;
      busy_q   <= 1'b0;
    end else begin
      state  <= state_n;
      busy_q <= busy;
      if (fifo_pop) begin
        mem_addr <= fifo_dout.addr;
        mem_data <= fifo_dout.data;
      end
    end
  end

  assign mem_req    = (state == WRITE);
  assign busy       = s1_valid || !fifo_empty || (state == WRITE);
  assign drain_done = busy_q && !busy;

endmodule
